rcvr_fifo: RTL and testbench

Parametrised serial frame receiver, successor to the single-byte receiver.
- Hunts a bit stream for a HEAD_W-bit header pattern MATCH, then captures the following DATA_W-bit body MSB-first.
- Completed words are buffered in a FIFO_DEPTH-entry first-word-fall-through FIFO, so a slow reader does not lose back-to-back frames.
- Sits between the serial line sampler and the host register interface.

---
 rtl/rcvr_fifo.sv | 195 +++++++++++++++++++
 tb/tb_rcvr_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rcvr_fifo.sv
// Serial frame receiver: hunts for a MATCH header, captures a DATA_W body MSB-first and
// queues words in a first-word-fall-through FIFO. Define RCVR_PARITY_EN for a trailing even-parity bit.
module rcvr_fifo #(
    parameter int                HEAD_W     = 8,
    parameter logic [HEAD_W-1:0] MATCH      = 8'hA5,
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          data_in,
    input  logic                          reading,
    output logic                          ready,
    output logic                          overrun,
    output logic [DATA_W-1:0]             data_out,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        BODY   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HEAD_W-2:0]   head_q, head_d;
    logic [HEAD_W-1:0]   head_cat_s;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   body_q, body_d;
    logic                push_s;
    logic [DATA_W-1:0]   push_word_s;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]       level_q, level_d;
    logic                ready_q, ready_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                pop_s, full_s, accept_s, drop_s;

`ifdef RCVR_PARITY_EN
    logic                parity_fail_s;
    logic                perr_q;
`endif

    // Frame FSM: header hunt, body shift and optional parity check.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        cnt_d       = cnt_q;
        body_d      = body_q;
        push_s      = 1'b0;
        push_word_s = body_q;
        head_cat_s  = {head_q, data_in};
`ifdef RCVR_PARITY_EN
        parity_fail_s = 1'b0;
`endif
        case (state_q)
            HUNT: begin
                if (head_cat_s == MATCH) begin
                    state_d = BODY;
                    head_d  = {(HEAD_W-1){1'b0}};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    head_d  = head_cat_s[HEAD_W-2:0];
                end
            end
            BODY: begin
                head_d = {(HEAD_W-1){1'b0}};
                body_d = {body_q[DATA_W-2:0], data_in};
                if (cnt_q == CW'(DATA_W-1)) begin
                    cnt_d = {CW{1'b0}};
`ifdef RCVR_PARITY_EN
                    state_d = PARITY;
`else
                    state_d     = HUNT;
                    push_s      = 1'b1;
                    push_word_s = body_d;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
`ifdef RCVR_PARITY_EN
            PARITY: begin
                state_d = HUNT;
                head_d  = {(HEAD_W-1){1'b0}};
                if (((^body_q) ^ data_in) == 1'b1) begin
                    parity_fail_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end
`endif
            default: begin
                state_d = HUNT;
                head_d  = {(HEAD_W-1){1'b0}};
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // FIFO bookkeeping; a pop frees the slot a same-edge push needs when full.
    always_comb begin
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        pop_s     = reading & (level_q != {LW{1'b0}});
        full_s    = (level_q == LW'(FIFO_DEPTH));
        accept_s  = push_s & (~full_s | pop_s);
        drop_s    = push_s & full_s & ~pop_s;
        if (accept_s) begin
            mem_d[wr_q] = push_word_s;
            wr_d        = wr_q + AW'(1'b1);
        end else begin
            wr_d        = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1'b1);
        end else begin
            rd_d = rd_q;
        end
        case ({accept_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
        if (reading) begin
            overrun_d = 1'b0;
        end else if (drop_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
        ready_d    = (level_d != {LW{1'b0}});
        data_out_d = mem_d[rd_d];
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            head_q     <= {(HEAD_W-1){1'b0}};
            cnt_q      <= {CW{1'b0}};
            body_q     <= {DATA_W{1'b0}};
            mem_q      <= '{default: {DATA_W{1'b0}}};
            wr_q       <= {AW{1'b0}};
            rd_q       <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            data_out_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            cnt_q      <= cnt_d;
            body_q     <= body_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
        end
    end

`ifdef RCVR_PARITY_EN
    // One-cycle pulse for a frame discarded on parity failure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= parity_fail_s;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign ready    = ready_q;
    assign overrun  = overrun_q;
    assign data_out = data_out_q;
    assign level    = level_q;

endmodule

// File: tb/tb_rcvr_fifo.sv
// Bench for rcvr_fifo: queue-based frame model compared every cycle plus directed literal checks.
module tb_rcvr_fifo;
    localparam int         HEAD_W = 8;
    localparam logic [7:0] MATCH  = 8'hA5;
    localparam int         DATA_W = 8;
    localparam int         DEPTH  = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic       reading = 1'b0;
    logic       ready, overrun, parity_err;
    logic [7:0] data_out;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [7:0] hist;
    int         body_left;
    bit         par_pending;
    logic [7:0] acc;
    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_perr;

    rcvr_fifo #(.HEAD_W(HEAD_W), .MATCH(MATCH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .reading(reading),
        .ready(ready), .overrun(overrun), .data_out(data_out), .level(level),
        .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        hist = 8'h00; body_left = 0; par_pending = 1'b0; acc = 8'h00;
        q.delete(); m_ovr = 1'b0; m_perr = 1'b0;
    endfunction

    function automatic void model_update(input bit d, input bit rd);
        bit         push = 1'b0;
        bit         dopop;
        bit         drop = 1'b0;
        int         was;
        m_perr = 1'b0;
        if (par_pending) begin
            par_pending = 1'b0;
            if (((^acc) ^ d) == 1'b0) push = 1'b1;
            else m_perr = 1'b1;
        end else if (body_left > 0) begin
            acc = {acc[6:0], d};
            body_left--;
            if (body_left == 0) begin
`ifdef RCVR_PARITY_EN
                par_pending = 1'b1;
`else
                push = 1'b1;
`endif
            end
        end else begin
            hist = {hist[6:0], d};
            if (hist == MATCH) begin
                body_left = DATA_W;
                hist = 8'h00;
            end
        end
        was   = q.size();
        dopop = rd && (was > 0);
        if (push && was == DEPTH && !dopop) drop = 1'b1;
        if (dopop) void'(q.pop_front());
        if (push && !drop) q.push_back(acc);
        if (rd) m_ovr = 1'b0;
        else if (drop) m_ovr = 1'b1;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        chk("ready", {31'd0, ready}, {31'd0, q.size() != 0});
        chk("level", {29'd0, level}, q.size());
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
        if (q.size() != 0) chk("data_out", {24'd0, data_out}, {24'd0, q[0]});
    end

    task automatic step(input bit d, input bit rd);
        data_in = d;
        reading = rd;
        @(posedge clock);
        #1;
        model_update(d, rd);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rd_last);
        for (int i = 7; i >= 0; i--) step(b[i], (i == 0) ? rd_last : 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] body, input bit rd_last);
        send_byte(8'hA5, 1'b0);
`ifdef RCVR_PARITY_EN
        send_byte(body, 1'b0);
        step(^body, rd_last);
`else
        send_byte(body, rd_last);
`endif
    endtask

    task automatic pop();
        step(1'b0, 1'b1);
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b1;

        // single frame, then pop
        send_frame(8'h3C, 1'b0);
        chk("t1_ready", {31'd0, ready}, 32'd1);
        chk("t1_data", {24'd0, data_out}, 32'h3C);
        chk("t1_level", {29'd0, level}, 32'd1);
        pop();
        chk("t1_pop_ready", {31'd0, ready}, 32'd0);
        chk("t1_pop_level", {29'd0, level}, 32'd0);

        // body equal to MATCH is data, not a header
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        send_frame(8'h81, 1'b0);
        send_frame(8'hA5, 1'b0);
        chk("t2_level", {29'd0, level}, 32'd2);
        chk("t2_first", {24'd0, data_out}, 32'h81);
        pop();
        chk("t2_second", {24'd0, data_out}, 32'hA5);
        pop();
        chk("t2_empty", {29'd0, level}, 32'd0);

        // overflow with no reader
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0);
        chk("t3_level", {29'd0, level}, 32'd4);
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        chk("t3_head", {24'd0, data_out}, 32'h01);
        for (int k = 1; k <= 4; k++) begin
            chk("t3_order", {24'd0, data_out}, k);
            pop();
            if (k == 1) chk("t3_ovr_clr", {31'd0, overrun}, 32'd0);
        end
        chk("t3_drained", {31'd0, ready}, 32'd0);

        // push and pop on the same edge while full
        for (int k = 16; k <= 19; k++) send_frame(8'(k), 1'b0);
        send_frame(8'h14, 1'b1);
        chk("t4_overrun", {31'd0, overrun}, 32'd0);
        chk("t4_level", {29'd0, level}, 32'd4);
        for (int k = 17; k <= 20; k++) begin
            chk("t4_order", {24'd0, data_out}, k);
            pop();
        end

        // reset mid-frame
        send_frame(8'h77, 1'b0);
        send_byte(8'hA5, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        chk("t5_ready", {31'd0, ready}, 32'd0);
        chk("t5_level", {29'd0, level}, 32'd0);
        chk("t5_data", {24'd0, data_out}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        chk("t5_noword", {29'd0, level}, 32'd0);
        send_frame(8'h5A, 1'b0);
        chk("t5_next", {24'd0, data_out}, 32'h5A);
        pop();

`ifdef RCVR_PARITY_EN
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        step(1'b0, 1'b0);
        chk("t6_pass_level", {29'd0, level}, 32'd1);
        chk("t6_pass_perr", {31'd0, parity_err}, 32'd0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3D, 1'b0);
        step(1'b0, 1'b0);
        chk("t6_fail_perr", {31'd0, parity_err}, 32'd1);
        chk("t6_fail_level", {29'd0, level}, 32'd1);
        step(1'b0, 1'b0);
        chk("t6_perr_pulse", {31'd0, parity_err}, 32'd0);
        pop();
`endif

        repeat (2) step(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
